regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/regfile_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, register index map and FSM state type
// for the register-file arbiter.
package regfile_pkg;
    localparam int REG_COUNT = 11;
    localparam int REG_WIDTH = 12;
    localparam int ADDR_W    = 4;
    localparam int R      = 0;
    localparam int row    = 1;
    localparam int cAT    = 2;
    localparam int cB     = 3;
    localparam int rnow   = 4;
    localparam int cATnow = 5;
    localparam int cBnow  = 6;
    localparam int alphap = 7;
    localparam int betap  = 8;
    localparam int gammap = 9;
    localparam int Total  = 10;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on a tie the requester not
// granted last wins, and the pointer moves only when a grant is accepted.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    logic last_q, last_d;
    always_comb begin
        gnt    = &req ? (last_q ? 2'b01 : 2'b10) : req;
        last_d = accept ? gnt[1] : last_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= 1'b1;
        else        last_q <= last_d;
    end
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: serialises two request ports onto one register file
// through an IDLE/EXEC/RESP sequence (one access per three cycles).
module regfile_arbiter #(
    parameter int REG_COUNT = regfile_pkg::REG_COUNT,
    parameter int REG_WIDTH = regfile_pkg::REG_WIDTH,
    parameter int ADDR_W    = regfile_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic                 req0_we,
    input  logic [ADDR_W-1:0]    req0_addr,
    input  logic [REG_WIDTH-1:0] req0_wdata,
    output logic                 req0_ready,
    output logic                 req0_rvalid,
    output logic [REG_WIDTH-1:0] req0_rdata,
    output logic                 req0_err,
    input  logic                 req1_valid,
    input  logic                 req1_we,
    input  logic [ADDR_W-1:0]    req1_addr,
    input  logic [REG_WIDTH-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 req1_rvalid,
    output logic [REG_WIDTH-1:0] req1_rdata,
    output logic                 req1_err,
    output logic [REG_COUNT-1:0] rf_read_en,
    output logic [REG_COUNT-1:0] rf_write_en,
    output logic [REG_WIDTH-1:0] rf_datain,
    input  logic [REG_WIDTH-1:0] rf_dataout
);
    import regfile_pkg::*;
    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [REG_WIDTH-1:0] wdata_q, wdata_d;
    logic [REG_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]           gnt;
    logic                 accept, legal, exec, rsp;
    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .gnt    (gnt)
    );
    // ready is gated by reset so every output reads 0 while reset is held
    assign accept = (state_q == IDLE) && reset && (req0_valid || req1_valid);
    assign legal  = 32'(addr_q) < REG_COUNT;
    assign exec   = state_q == EXEC;
    assign rsp    = state_q == RESP;
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = EXEC;
                owner_d = gnt[1];
                we_d    = gnt[1] ? req1_we    : req0_we;
                addr_d  = gnt[1] ? req1_addr  : req0_addr;
                wdata_d = gnt[1] ? req1_wdata : req0_wdata;
            end
            EXEC: begin
                state_d = RESP;
                rdata_d = (!we_q && legal) ? rf_dataout : '0;
                err_d   = !legal;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        rf_write_en = (exec && we_q && legal)  ? REG_COUNT'(1) << addr_q : '0;
        rf_read_en  = (exec && !we_q && legal) ? REG_COUNT'(1) << addr_q : '0;
        rf_datain   = (exec && we_q && legal)  ? wdata_q : '0;
        req0_ready  = accept && gnt[0];
        req1_ready  = accept && gnt[1];
        req0_rvalid = rsp && !owner_q;
        req1_rvalid = rsp && owner_q;
        req0_rdata  = req0_rvalid ? rdata_q : '0;
        req1_rdata  = req1_rvalid ? rdata_q : '0;
        req0_err    = req0_rvalid && err_q;
        req1_err    = req1_rvalid && err_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed and random-traffic checks of regfile_arbiter
// against a behavioural register file and a shadow copy of its contents.
module tb_regfile_arbiter;
    import regfile_pkg::*;
    logic                 clk = 0, reset = 0;
    logic [1:0]           valid = '0, we = '0, ready, rvalid, err;
    logic [ADDR_W-1:0]    addr [2];
    logic [REG_WIDTH-1:0] wdata [2], rdata [2];
    logic [REG_COUNT-1:0] rf_read_en, rf_write_en;
    logic [REG_WIDTH-1:0] rf_datain, rf_dataout;
    logic [REG_WIDTH-1:0] rf [REG_COUNT];
    logic [REG_WIDTH-1:0] shadow [REG_COUNT];
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    regfile_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(valid[0]), .req0_we(we[0]), .req0_addr(addr[0]), .req0_wdata(wdata[0]),
        .req0_ready(ready[0]), .req0_rvalid(rvalid[0]), .req0_rdata(rdata[0]), .req0_err(err[0]),
        .req1_valid(valid[1]), .req1_we(we[1]), .req1_addr(addr[1]), .req1_wdata(wdata[1]),
        .req1_ready(ready[1]), .req1_rvalid(rvalid[1]), .req1_rdata(rdata[1]), .req1_err(err[1]),
        .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
        .rf_datain(rf_datain), .rf_dataout(rf_dataout)
    );
    always @(posedge clk or negedge reset) begin
        if (!reset) for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        else for (int i = 0; i < REG_COUNT; i++) if (rf_write_en[i]) rf[i] <= rf_datain;
    end
    always_comb begin
        rf_dataout = '0;
        for (int i = 0; i < REG_COUNT; i++) if (rf_read_en[i]) rf_dataout = rf[i];
    end
    always @(negedge clk) begin
        vectors++;
        assert ($onehot0(rf_read_en) && $onehot0(rf_write_en) && !(|rf_read_en && |rf_write_en))
        else begin
            miscompares++;
            $error("FAIL enables: rd=%b wr=%b expected one-hot-or-zero, not both", rf_read_en, rf_write_en);
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_rvalid"}, 32'(rvalid), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_rdata0"}, 32'(rdata[0]), 0);
        chk({tag, "_rdata1"}, 32'(rdata[1]), 0);
        chk({tag, "_rd_en"}, 32'(rf_read_en), 0);
        chk({tag, "_wr_en"}, 32'(rf_write_en), 0);
        chk({tag, "_datain"}, 32'(rf_datain), 0);
    endtask
    task automatic txn(input int p, input logic w, input logic [ADDR_W-1:0] a, input logic [REG_WIDTH-1:0] d);
        logic [REG_WIDTH-1:0] exp_r;
        logic exp_e;
        int n;
        exp_e = 32'(a) >= REG_COUNT;
        exp_r = (w || exp_e) ? '0 : shadow[a];
        we[p] = w; addr[p] = a; wdata[p] = d; valid[p] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready[p] && n < 20) begin @(negedge clk); n++; end
        chk("ready_wait", 32'(ready[p]), 1);
        if (!ready[p]) begin valid[p] = 1'b0; return; end
        @(posedge clk); #1 valid[p] = 1'b0;
        @(negedge clk);
        chk("wr_en", 32'(rf_write_en), (w && !exp_e) ? 32'(1) << a : 0);
        chk("rd_en", 32'(rf_read_en), (!w && !exp_e) ? 32'(1) << a : 0);
        chk("datain", 32'(rf_datain), (w && !exp_e) ? 32'(d) : 0);
        chk("exec_rvalid", 32'(rvalid), 0);
        chk("exec_ready", 32'(ready), 0);
        @(negedge clk);
        chk("rvalid", 32'(rvalid), 32'(1) << p);
        chk("rdata", 32'(rdata[p]), 32'(exp_r));
        chk("err", 32'(err[p]), 32'(exp_e));
        chk("other_rdata", 32'(rdata[1-p]), 0);
        chk("resp_enables", 32'(rf_read_en | rf_write_en), 0);
        if (w && !exp_e) shadow[a] = d;
        @(posedge clk); #1;
    endtask
    initial begin
        int n;
        for (int i = 0; i < REG_COUNT; i++) shadow[i] = '0;
        addr[0] = 4'd3; addr[1] = 4'd4; wdata[0] = '0; wdata[1] = '0;
        valid = 2'b11;
        #2 chk_quiet("reset");
        // release at a falling edge so the first rising edge can accept
        @(negedge clk) reset = 1'b1;
        #1 chk("first_tie", 32'(ready), 32'b01);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (ready == 2'b00 && n < 10) begin @(negedge clk); n++; end
            chk("alt_grant", 32'(ready), k[0] ? 32'b10 : 32'b01);
            @(posedge clk); #1;
        end
        valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 chk_quiet("idle");
        txn(0, 1'b1, 4'd2, 12'h0A5);
        txn(0, 1'b0, 4'd2, 12'h000);
        txn(1, 1'b0, 4'd11, 12'h000);
        txn(1, 1'b1, 4'd15, 12'h123);
        txn(1, 1'b1, 4'd0, 12'h800);
        txn(0, 1'b0, 4'd0, 12'h000);
        for (int t = 0; t < 1000; t++)
            txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, REG_COUNT - 1)), 12'($urandom));
        we[0] = 1'b1; addr[0] = 4'd10; wdata[0] = 12'hFFF; valid[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready[0] && n < 20) begin @(negedge clk); n++; end
        chk("rst_ready_wait", 32'(ready[0]), 1);
        @(posedge clk); #1;
        chk("rst_exec_wr_en", 32'(rf_write_en), 32'(1) << 10);
        #2 reset = 1'b0;
        #1 chk_quiet("rst_exec");
        for (int i = 0; i < REG_COUNT; i++) shadow[i] = '0;
        repeat (3) begin @(negedge clk); chk("rst_hold_rvalid", 32'(rvalid), 0); end
        we = 2'b00; valid = 2'b11;
        @(negedge clk) reset = 1'b1;
        #1 chk("rst_pointer", 32'(ready), 32'b01);
        @(posedge clk); #1 valid = 2'b00;
        @(negedge clk);
        chk("post_rst_rd_en", 32'(rf_read_en), 32'(1) << 10);
        @(negedge clk);
        chk("post_rst_rvalid", 32'(rvalid), 32'b01);
        chk("post_rst_rdata", 32'(rdata[0]), 0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
